// File: rtl/tinydumbcpu_pkg.sv
// Shared types and width constants for the tape arbiter and its starvation counter.
package tinydumbcpu_pkg;

  localparam int TAPE_ADDR_W  = 16;
  localparam int TAPE_DATA_W  = 8;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE        = 2'd0,
    ARB_SHARED      = 2'd1,
    ARB_HOST_LOCKED = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_HOST = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/tape_arb_starve_ctr.sv
// Saturating count of consecutive cycles the host has been denied access.
module tape_arb_starve_ctr
  import tinydumbcpu_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_clear,
  input  logic                    i_inc,
  output logic [STARVE_CNT_W-1:0] o_count
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != LIMIT_V)) begin
      r_count <= r_count + STARVE_CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/tape_arbiter.sv
// Two-requester arbiter for the tape RAM: core has priority, host can lock bursts
// and gets forced priority after STARVE_LIMIT denied cycles.
module tape_arbiter
  import tinydumbcpu_pkg::*;
#(
  parameter int ADDR_WIDTH   = TAPE_ADDR_W,
  parameter int DATA_WIDTH   = TAPE_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic                  host_lock,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_e              r_state;
  rd_owner_e               r_rd_owner;
  logic [DATA_WIDTH-1:0]   r_core_rdata;
  logic [DATA_WIDTH-1:0]   r_host_rdata;
  logic [STARVE_CNT_W-1:0] w_starve_cnt;
  logic                    w_starve_hit;
  logic                    w_core_gnt;
  logic                    w_host_gnt;

  assign w_starve_hit = host_req && (w_starve_cnt == LIMIT_V);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_core_gnt = 1'b0;
    w_host_gnt = 1'b0;
    if (!reset) begin
      if (r_state == ARB_HOST_LOCKED) begin
        w_host_gnt = host_req;
      end else if (w_starve_hit) begin
        w_host_gnt = 1'b1;
      end else if (core_req) begin
        w_core_gnt = 1'b1;
      end else begin
        w_host_gnt = host_req;
      end
    end
  end

  assign core_gnt  = w_core_gnt;
  assign host_gnt  = w_host_gnt;
  assign mem_en    = w_core_gnt | w_host_gnt;
  assign mem_we    = w_core_gnt ? core_we    : (w_host_gnt ? host_we    : 1'b0);
  assign mem_addr  = w_core_gnt ? core_addr  : (w_host_gnt ? host_addr  : '0);
  assign mem_wdata = w_core_gnt ? core_wdata : (w_host_gnt ? host_wdata : '0);

  tape_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clock   (clock),
    .reset   (reset),
    .i_clear (w_host_gnt | ~host_req),
    .i_inc   (host_req & ~w_host_gnt),
    .o_count (w_starve_cnt)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_rd_owner   <= OWN_NONE;
      r_core_rdata <= '0;
      r_host_rdata <= '0;
    end else begin
      unique case (r_state)
        ARB_IDLE: begin
          if (core_req || host_req) r_state <= ARB_SHARED;
        end
        ARB_SHARED: begin
          if (w_host_gnt && host_lock)     r_state <= ARB_HOST_LOCKED;
          else if (!core_req && !host_req) r_state <= ARB_IDLE;
        end
        ARB_HOST_LOCKED: begin
          if (!host_lock) r_state <= ARB_SHARED;
        end
        default: r_state <= ARB_IDLE;
      endcase

      if (w_core_gnt && !core_we)      r_rd_owner <= OWN_CORE;
      else if (w_host_gnt && !host_we) r_rd_owner <= OWN_HOST;
      else                             r_rd_owner <= OWN_NONE;

      // Capture returned data so rdata keeps showing it after rvalid falls.
      if (r_rd_owner == OWN_CORE) r_core_rdata <= mem_rdata;
      if (r_rd_owner == OWN_HOST) r_host_rdata <= mem_rdata;
    end
  end

  assign core_rvalid = (r_rd_owner == OWN_CORE);
  assign host_rvalid = (r_rd_owner == OWN_HOST);
  assign core_rdata  = core_rvalid ? mem_rdata : r_core_rdata;
  assign host_rdata  = host_rvalid ? mem_rdata : r_host_rdata;

endmodule

// File: tb/tb_tape_arbiter.sv
// Randomized and directed checks of tape_arbiter against a cycle-level reference model.
module tb_tape_arbiter;

  localparam int AW    = 16;
  localparam int DW    = 8;
  localparam int LIMIT = 4;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          host_req, host_we, host_lock, host_gnt, host_rvalid;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  tape_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_gnt    (core_gnt),
    .core_rvalid (core_rvalid),
    .core_rdata  (core_rdata),
    .host_req    (host_req),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_lock   (host_lock),
    .host_gnt    (host_gnt),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] init_val(int a);
    return DW'(a * 37 + 11);
  endfunction

  // Synchronous tape RAM, one-cycle read latency.
  logic [DW-1:0] ram [0:DEPTH-1];
  logic [DW-1:0] ram_q = '0;
  initial for (int i = 0; i < DEPTH; i++) ram[i] = init_val(i);
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_q <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_q;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: ownership flags, denied-cycle count, pending read returns, shadow tape.
  bit            m_locked, m_active;
  int            m_starve;
  bit            m_cpend, m_hpend;
  logic [DW-1:0] m_cdata, m_hdata, m_clast, m_hlast;
  logic [DW-1:0] shadow [0:DEPTH-1];
  bit            g_core, g_host;

  task automatic apply(input bit rst,
                       input bit c_req, input bit c_we, input logic [AW-1:0] c_addr,
                       input logic [DW-1:0] c_wd,
                       input bit h_req, input bit h_we, input logic [AW-1:0] h_addr,
                       input logic [DW-1:0] h_wd, input bit h_lock);
    bit            ec, eh;
    bit            ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clock);
    reset = rst;
    core_req = c_req; core_we = c_we; core_addr = c_addr; core_wdata = c_wd;
    host_req = h_req; host_we = h_we; host_addr = h_addr; host_wdata = h_wd;
    host_lock = h_lock;
    #1;
    ec = 1'b0;
    eh = 1'b0;
    if (!rst) begin
      if (m_locked) eh = h_req;
      else begin
        eh = h_req && ((m_starve == LIMIT) || !c_req);
        ec = c_req && !eh;
      end
    end
    ewe = ec ? c_we   : (eh ? h_we   : 1'b0);
    ea  = ec ? c_addr : (eh ? h_addr : '0);
    ed  = ec ? c_wd   : (eh ? h_wd   : '0);
    check("core_gnt",    core_gnt,    ec);
    check("host_gnt",    host_gnt,    eh);
    check("mem_en",      mem_en,      ec | eh);
    check("mem_we",      mem_we,      ewe);
    check("mem_addr",    mem_addr,    ea);
    check("mem_wdata",   mem_wdata,   ed);
    check("core_rvalid", core_rvalid, m_cpend);
    check("host_rvalid", host_rvalid, m_hpend);
    check("core_rdata",  core_rdata,  m_cpend ? m_cdata : m_clast);
    check("host_rdata",  host_rdata,  m_hpend ? m_hdata : m_hlast);
    g_core = ec;
    g_host = eh;
    if (m_cpend) m_clast = m_cdata;
    if (m_hpend) m_hlast = m_hdata;
    m_cpend = 1'b0;
    m_hpend = 1'b0;
    if (rst) begin
      m_locked = 1'b0; m_active = 1'b0; m_starve = 0;
      m_clast = '0;    m_hlast = '0;
    end else begin
      if (ec) begin
        if (c_we) shadow[c_addr] = c_wd;
        else begin m_cpend = 1'b1; m_cdata = shadow[c_addr]; end
      end
      if (eh) begin
        if (h_we) shadow[h_addr] = h_wd;
        else begin m_hpend = 1'b1; m_hdata = shadow[h_addr]; end
      end
      m_starve = (h_req && !eh) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      if (m_locked) begin
        m_locked = h_lock;
        m_active = 1'b1;
      end else begin
        m_locked = m_active && eh && h_lock;
        m_active = c_req || h_req;
      end
    end
  endtask

  task automatic idle();
    apply(0, 0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  bit            cr, cw, hr, hw, hl, rs;
  logic [AW-1:0] ca, ha;
  logic [DW-1:0] cd, hd;
  int            k;

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
    reset = 1'b1;
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0; host_lock = 0;
    repeat (2) @(posedge clock);
    m_locked = 0; m_active = 0; m_starve = 0; m_cpend = 0; m_hpend = 0;
    m_cdata = '0; m_hdata = '0; m_clast = '0; m_hlast = '0;

    // Reset state, then core-only read.
    apply(1, 0, 0, '0, '0, 0, 0, '0, '0, 0);
    apply(0, 1, 1, 16'h0010, 8'h5A, 0, 0, '0, '0, 0);
    apply(0, 1, 0, 16'h0010, '0, 0, 0, '0, '0, 0);
    check("ro_gnt", core_gnt, 1);
    idle();
    check("ro_rvalid", core_rvalid, 1);
    check("ro_rdata", core_rdata, 8'h5A);

    // Simultaneous requests: host wins only once starved.
    idle();
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, 16'h0020, '0, 1, 0, 16'h0021, '0, 0);
      check("starve_core_gnt", core_gnt, (i < 4) ? 1 : 0);
      check("starve_host_gnt", host_gnt, (i == 4) ? 1 : 0);
    end
    apply(0, 1, 0, 16'h0020, '0, 1, 0, 16'h0022, '0, 0);
    check("starve_cleared", core_gnt, 1);
    idle();

    // Host locked burst while the core keeps requesting.
    k = 0;
    for (int c = 0; c < 12 && k < 4; c++) begin
      apply(0, 1, 0, 16'h0030, '0, 1, 1, AW'(k), 8'hAA, 1);
      if (g_host) begin
        check("burst_core_blocked", core_gnt, 0);
        check("burst_host_gnt", host_gnt, 1);
        k++;
      end
    end
    check("burst_len", k, 4);
    apply(0, 1, 0, 16'h0030, '0, 0, 0, '0, '0, 0);
    check("unlock_core_still_blocked", core_gnt, 0);
    apply(0, 1, 0, 16'h0030, '0, 0, 0, '0, '0, 0);
    check("unlock_core_gnt", core_gnt, 1);
    for (int a = 0; a < 4; a++) begin
      apply(0, 1, 0, AW'(a), '0, 0, 0, '0, '0, 0);
      idle();
      check("burst_readback", core_rdata, 8'hAA);
    end

    // Alternating reads, no bubbles between returns.
    apply(0, 1, 1, 16'h0001, 8'h11, 0, 0, '0, '0, 0);
    apply(0, 0, 0, '0, '0, 1, 1, 16'h0002, 8'h22, 0);
    for (int r = 0; r < 4; r++) begin
      apply(0, 1, 0, 16'h0001, '0, 0, 0, '0, '0, 0);
      if (r > 0) begin
        check("alt_host_rvalid", host_rvalid, 1);
        check("alt_host_rdata", host_rdata, 8'h22);
        check("alt_core_quiet", core_rvalid, 0);
      end
      apply(0, 0, 0, '0, '0, 1, 0, 16'h0002, '0, 0);
      check("alt_core_rvalid", core_rvalid, 1);
      check("alt_core_rdata", core_rdata, 8'h11);
      check("alt_host_quiet", host_rvalid, 0);
    end
    idle();
    check("alt_last_host", host_rdata, 8'h22);

    // Reset in the same cycle as a core read request.
    apply(1, 1, 0, 16'h0010, '0, 0, 0, '0, '0, 0);
    check("rst_gnt", core_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    idle();
    check("rst_rvalid", core_rvalid, 0);
    check("rst_core_rdata", core_rdata, 0);
    check("rst_host_rdata", host_rdata, 0);

    // Write then read at 0x0100.
    apply(0, 1, 1, 16'h0100, 8'h7F, 0, 0, '0, '0, 0);
    apply(0, 1, 0, 16'h0100, '0, 0, 0, '0, '0, 0);
    idle();
    check("wr_rd_0100", core_rdata, 8'h7F);

    // Random traffic; a requester holds its request until granted.
    cr = 0; hr = 0; hl = 0; cw = 0; hw = 0; ca = '0; ha = '0; cd = '0; hd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!(cr && !g_core)) begin
        cr = ($urandom_range(0, 3) != 0);
        cw = ($urandom_range(0, 2) == 0);
        ca = AW'($urandom_range(0, 15));
        cd = DW'($urandom);
      end
      if (!(hr && !g_host)) begin
        hr = ($urandom_range(0, 1) != 0);
        hw = ($urandom_range(0, 2) == 0);
        ha = AW'($urandom_range(0, 15));
        hd = DW'($urandom);
      end
      if ($urandom_range(0, 7) == 0) hl = ~hl;
      rs = ($urandom_range(0, 199) == 0);
      apply(rs, cr, cw, ca, cd, hr, hw, ha, hd, hl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tape_arbiter.md
TAPE_ARBITER -- requirements
Module: tape_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, meaning tape address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning tape cell width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied host cycles before the host gets forced priority; legal range 1..15.
REQ-004 clock  input  1  single clock, all logic on the rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 core_req / core_we  input  1 each  core access request / write qualifier.
REQ-007 core_addr  input  ADDR_WIDTH, and core_wdata  input  DATA_WIDTH.
REQ-008 core_gnt  output  1  combinational grant; access is performed this cycle.
REQ-009 core_rvalid  output  1, and core_rdata  output  DATA_WIDTH: read return.
REQ-010 host_req, host_we, host_addr, host_wdata, host_gnt, host_rvalid, host_rdata SHALL mirror the core_* ports for the host (loader/debug) requester.
REQ-011 host_lock  input  1  host requests exclusive ownership for a burst.
REQ-012 mem_en, mem_we  output  1 each  tape RAM strobes.
REQ-013 mem_addr  output  ADDR_WIDTH, and mem_wdata  output  DATA_WIDTH.
REQ-014 mem_rdata  input  DATA_WIDTH  synchronous RAM data, valid 1 cycle after mem_en with !mem_we.

Function
REQ-015 SHALL implement FSM states IDLE, SHARED and HOST_LOCKED.
- IDLE→SHARED on any req.
- SHARED→HOST_LOCKED when host granted with host_lock=1.
- HOST_LOCKED→SHARED when host_lock=0.
- SHARED→IDLE when no req.
REQ-016 In IDLE/SHARED at most one gnt per cycle.
- Priority: core wins ties, except host wins when starve_cnt==STARVE_LIMIT.
REQ-017 In HOST_LOCKED, core_gnt SHALL be 0; host_gnt=host_req.
REQ-018 mem_en SHALL equal core_gnt|host_gnt; mem_we, mem_addr and mem_wdata SHALL be muxed from the granted requester, with mem_addr/mem_wdata 0 when idle.
REQ-019 Requester rule: req/we/addr/wdata SHALL be held stable until gnt; the arbiter does not check this.
REQ-020 For a granted read, the owner's rvalid SHALL be 1 exactly one cycle later, with rdata=mem_rdata; the other rvalid stays 0.
REQ-021 rdata SHALL hold its last value when rvalid=0; writes produce no rvalid.
REQ-022 starve_cnt:
- increments (saturating at STARVE_LIMIT) each cycle host_req && !host_gnt;
- clears on host_gnt or !host_req.
REQ-023 Back-to-back grants to alternating requesters SHALL be allowed every cycle; read returns pipeline without bubbles.
REQ-024 Deasserting host_lock while host_req=0 in HOST_LOCKED SHALL transition to SHARED next cycle, with core eligible that cycle.

Reset
REQ-025 reset SHALL force the following, overriding all other activity:
- FSM=IDLE, starve_cnt=0, read-owner/pending=none;
- all gnt, rvalid, mem_en and mem_we = 0; rdata = 0.
REQ-026 A read granted in the cycle reset asserts SHALL NOT produce rvalid.

Structure
REQ-027 FSM state encoding and ADDR/DATA width constants SHALL live in the shared package tinydumbcpu_pkg.
REQ-028 The starvation counter SHALL be the one sub-module, tape_arb_starve_ctr (saturating, clear/increment).

Verification
REQ-029 Core-only read: core_req=1, we=0, addr=0x0010; RAM holds 0x5A there → core_gnt same cycle, core_rvalid=1 with 0x5A next cycle.
REQ-030 Simultaneous, STARVE_LIMIT=4: both req held → core granted 4 cycles, host granted on cycle 5, starve_cnt returns to 0.
REQ-031 Host burst: host_lock=1, writes 0xAA to 0x0000..0x0003 while core_req=1 → core_gnt=0 for all 4; core granted the cycle after lock drops.
REQ-032 Alternating reads core@0x0001 / host@0x0002 (data 0x11/0x22) → each rvalid only at its owner with correct data, no bubbles.
REQ-033 Reset mid-operation: core read granted, reset=1 same cycle → no rvalid next cycle, FSM IDLE, all outputs 0.
REQ-034 Write then read same address by core (0x0100 ← 0x7F) → read returns 0x7F.
